// File: rtl/vreg_writeback_sequencer.sv
// Vector register-file write-back sequencer: takes one grouped write command, then
// streams LMUL result beats into consecutive registers with tail-element byte masking.
module vreg_writeback_sequencer #(
  parameter int VLEN = 64,
  parameter int RA_W = 5,
  parameter int VL_W = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [RA_W-1:0]      cmd_dest,
  input  logic [2:0]           cmd_sew,
  input  logic [2:0]           cmd_lmul,
  input  logic [VL_W-1:0]      cmd_vl,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic [VLEN-1:0]      data_in,
  output logic [RA_W-1:0]      wa,
  output logic [VLEN-1:0]      wd,
  output logic                 wen,
  output logic [VLEN/8-1:0]    wbe,
  output logic                 done,
  output logic                 err
);

  localparam int NBYTES = VLEN / 8;
  localparam int ELEM_W = $clog2(8 * NBYTES);
  localparam int IDX_W  = ((VL_W > ELEM_W) ? VL_W : ELEM_W) + 1;

  typedef enum logic {S_IDLE, S_BEAT} state_t;

  // LMUL-1 doubles as the alignment mask for the group base register.
  function automatic logic [2:0] lmul_mask(input logic [1:0] lmul);
    case (lmul)
      2'd0:    lmul_mask = 3'd0;
      2'd1:    lmul_mask = 3'd1;
      2'd2:    lmul_mask = 3'd3;
      default: lmul_mask = 3'd7;
    endcase
  endfunction

  state_t             r_state;
  state_t             w_next;
  logic [RA_W-1:0]    r_dest;
  logic [1:0]         r_sew;
  logic [1:0]         r_lmul;
  logic [VL_W-1:0]    r_vl;
  logic [2:0]         r_beat;
  logic [RA_W-1:0]    r_wa;
  logic [VLEN-1:0]    r_wd;
  logic               r_wen;
  logic [NBYTES-1:0]  r_wbe;
  logic               r_done;
  logic               r_err;

  logic               w_cmd_go;
  logic               w_cmd_bad;
  logic               w_last;
  logic [IDX_W-1:0]   w_base;
  logic [NBYTES-1:0]  w_wbe;

  assign w_cmd_go  = cmd_valid & cmd_ready;
  assign w_cmd_bad = cmd_sew[2] | cmd_lmul[2] |
                     ((cmd_dest & RA_W'(lmul_mask(cmd_lmul[1:0]))) != '0);
  assign w_last    = (r_beat == lmul_mask(r_lmul));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves w_next unassigned (no latch).
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_cmd_go && !w_cmd_bad && (cmd_vl != '0)) w_next = S_BEAT;
      S_BEAT:  if (data_valid && w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = (r_state == S_IDLE);
    data_ready = (r_state == S_BEAT);
  end

  // Element index of byte b in beat k is k*(VLEN/SEW) + b/(SEW/8); enable it while below vl.
  always_comb begin
    w_base = IDX_W'(r_beat) * (IDX_W'(NBYTES) >> r_sew);
    w_wbe  = '0;
    for (int b = 0; b < NBYTES; b++)
      w_wbe[b] = (w_base + (IDX_W'(b) >> r_sew)) < IDX_W'(r_vl);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dest <= '0;
      r_sew  <= '0;
      r_lmul <= '0;
      r_vl   <= '0;
      r_beat <= '0;
      r_wa   <= '0;
      r_wd   <= '0;
      r_wen  <= 1'b0;
      r_wbe  <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_wen  <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_go) begin
            if (w_cmd_bad) begin
              r_err <= 1'b1;
            end else if (cmd_vl == '0) begin
              r_done <= 1'b1;
            end else begin
              r_dest <= cmd_dest;
              r_sew  <= cmd_sew[1:0];
              r_lmul <= cmd_lmul[1:0];
              r_vl   <= cmd_vl;
              r_beat <= '0;
            end
          end
        end
        S_BEAT: begin
          if (data_valid) begin
            r_wa   <= r_dest + RA_W'(r_beat);
            r_wd   <= data_in;
            r_wbe  <= w_wbe;
            r_wen  <= |w_wbe;
            r_beat <= r_beat + 3'd1;
            r_done <= w_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign wa   = r_wa;
  assign wd   = r_wd;
  assign wen  = r_wen;
  assign wbe  = r_wbe;
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_vreg_writeback_sequencer.sv
// Directed bench for vreg_writeback_sequencer: inputs change and outputs are sampled
// on the falling edge, so each check sees the result of the preceding rising edge.
module tb_vreg_writeback_sequencer;

  localparam int VLEN = 64;
  localparam int RA_W = 5;
  localparam int VL_W = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [RA_W-1:0]   cmd_dest;
  logic [2:0]        cmd_sew;
  logic [2:0]        cmd_lmul;
  logic [VL_W-1:0]   cmd_vl;
  logic              data_valid;
  logic              data_ready;
  logic [VLEN-1:0]   data_in;
  logic [RA_W-1:0]   wa;
  logic [VLEN-1:0]   wd;
  logic              wen;
  logic [VLEN/8-1:0] wbe;
  logic              done;
  logic              err;

  int total = 0;
  int bad   = 0;

  logic [17:0] got, exp;

  vreg_writeback_sequencer #(.VLEN(VLEN), .RA_W(RA_W), .VL_W(VL_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dest(cmd_dest), .cmd_sew(cmd_sew), .cmd_lmul(cmd_lmul), .cmd_vl(cmd_vl),
    .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
    .wa(wa), .wd(wd), .wen(wen), .wbe(wbe), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Observed bundle: {wa, wbe, wen, done, err, cmd_ready, data_ready}
  function automatic logic [17:0] obs();
    return {wa, wbe, wen, done, err, cmd_ready, data_ready};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_cmd(input logic [RA_W-1:0] d, input logic [2:0] s,
                         input logic [2:0] l, input logic [VL_W-1:0] v);
    cmd_valid = 1'b1;
    cmd_dest  = d;
    cmd_sew   = s;
    cmd_lmul  = l;
    cmd_vl    = v;
  endtask

  task automatic test_reset();
    rst = 1'b0; cmd_valid = 1'b0; cmd_dest = '0; cmd_sew = '0; cmd_lmul = '0;
    cmd_vl = '0; data_valid = 1'b0; data_in = '0;
    repeat (3) tick();
    got = obs(); exp = {5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; total++;
    if (got !== exp) begin bad++; $display("FAIL reset_outputs: got %h exp %h", got, exp); end
    total++;
    if (wd !== 64'h0) begin bad++; $display("FAIL reset_wd: got %h exp 0", wd); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    set_cmd(5'd3, 3'b000, 3'b000, 7'd5);
    tick();
    cmd_valid = 1'b0;
    total++;
    if ({cmd_ready, data_ready, wen, done, err} !== 5'b01000) begin
      bad++; $display("FAIL basic_enter_beat: got %b exp 01000", {cmd_ready, data_ready, wen, done, err});
    end
    data_valid = 1'b1; data_in = 64'h1122334455667788;
    tick();
    data_valid = 1'b0;
    got = obs(); exp = {5'd3, 8'h1F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; total++;
    if (got !== exp) begin bad++; $display("FAIL basic_write: got %h exp %h", got, exp); end
    total++;
    if (wd !== 64'h1122334455667788) begin bad++; $display("FAIL basic_wd: got %h exp 1122334455667788", wd); end
    tick();
    got = obs(); exp = {5'd3, 8'h1F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; total++;
    if (got !== exp) begin bad++; $display("FAIL basic_hold: got %h exp %h", got, exp); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_wbe [4];
    exp_wbe = '{8'hFF, 8'hFF, 8'h0F, 8'h00};
    set_cmd(5'd8, 3'b010, 3'b010, 7'd5);
    tick();
    cmd_valid = 1'b0;
    data_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data_in = 64'hA5A5_0000_0000_0000 | 64'(k);
      tick();
      got = obs();
      exp = {5'(8 + k), exp_wbe[k], (k < 3), (k == 3), 1'b0, (k == 3), (k != 3)};
      total++;
      if (got !== exp) begin bad++; $display("FAIL group_beat%0d: got %h exp %h", k, got, exp); end
      total++;
      if (wd !== (64'hA5A5_0000_0000_0000 | 64'(k))) begin
        bad++; $display("FAIL group_wd%0d: got %h exp %h", k, wd, 64'hA5A5_0000_0000_0000 | 64'(k));
      end
    end
    data_valid = 1'b0;
    // New command offered in the very cycle the group finishes: vl=0 completes at once.
    set_cmd(5'd0, 3'b000, 3'b000, 7'd0);
    tick();
    cmd_valid = 1'b0;
    total++;
    if ({wa, wen, done, err, cmd_ready} !== {5'd11, 4'b0101}) begin
      bad++; $display("FAIL b2b_vl0_done: got %h exp %h", {wa, wen, done, err, cmd_ready}, {5'd11, 4'b0101});
    end
  endtask

  task automatic test_backpressure();
    set_cmd(5'd4, 3'b001, 3'b001, 7'd8);
    tick();
    cmd_valid = 1'b0;
    data_valid = 1'b1; data_in = 64'h0101_0202_0303_0404;
    tick();
    got = obs(); exp = {5'd4, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; total++;
    if (got !== exp) begin bad++; $display("FAIL bp_first: got %h exp %h", got, exp); end
    data_valid = 1'b0;
    set_cmd(5'd3, 3'b000, 3'b001, 7'd5);
    tick();
    got = obs(); exp = {5'd4, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; total++;
    if (got !== exp) begin bad++; $display("FAIL bp_gap1: got %h exp %h", got, exp); end
    cmd_valid = 1'b0;
    tick();
    got = obs(); total++;
    if (got !== exp) begin bad++; $display("FAIL bp_gap2_cmd_ignored: got %h exp %h", got, exp); end
    data_valid = 1'b1; data_in = 64'hDEAD_BEEF_CAFE_F00D;
    tick();
    data_valid = 1'b0;
    got = obs(); exp = {5'd5, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; total++;
    if (got !== exp) begin bad++; $display("FAIL bp_second: got %h exp %h", got, exp); end
    total++;
    if (wd !== 64'hDEAD_BEEF_CAFE_F00D) begin bad++; $display("FAIL bp_wd: got %h exp deadbeefcafef00d", wd); end
  endtask

  task automatic test_reject();
    set_cmd(5'd3, 3'b000, 3'b001, 7'd4);
    tick();
    cmd_valid = 1'b0;
    total++;
    if ({wen, done, err, cmd_ready, data_ready} !== 5'b00110) begin
      bad++; $display("FAIL rej_misaligned: got %b exp 00110", {wen, done, err, cmd_ready, data_ready});
    end
    tick();
    total++;
    if ({wen, done, err, cmd_ready, data_ready} !== 5'b00010) begin
      bad++; $display("FAIL rej_err_pulse: got %b exp 00010", {wen, done, err, cmd_ready, data_ready});
    end
    set_cmd(5'd0, 3'b100, 3'b000, 7'd4);
    tick();
    cmd_valid = 1'b0;
    total++;
    if ({wen, done, err, cmd_ready, data_ready} !== 5'b00110) begin
      bad++; $display("FAIL rej_sew: got %b exp 00110", {wen, done, err, cmd_ready, data_ready});
    end
    set_cmd(5'd0, 3'b000, 3'b101, 7'd4);
    tick();
    cmd_valid = 1'b0;
    total++;
    if ({wen, done, err, cmd_ready, data_ready} !== 5'b00110) begin
      bad++; $display("FAIL rej_lmul: got %b exp 00110", {wen, done, err, cmd_ready, data_ready});
    end
    set_cmd(5'd2, 3'b000, 3'b000, 7'd0);
    tick();
    cmd_valid = 1'b0;
    total++;
    if ({wen, done, err, cmd_ready, data_ready} !== 5'b01010) begin
      bad++; $display("FAIL rej_vl0: got %b exp 01010", {wen, done, err, cmd_ready, data_ready});
    end
  endtask

  task automatic test_reset_mid();
    set_cmd(5'd8, 3'b011, 3'b011, 7'd64);
    tick();
    cmd_valid = 1'b0;
    data_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      data_in = 64'h7700 + 64'(k);
      tick();
      got = obs(); exp = {5'(8 + k), 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; total++;
      if (got !== exp) begin bad++; $display("FAIL rstmid_beat%0d: got %h exp %h", k, got, exp); end
    end
    rst = 1'b0;
    tick();
    got = obs(); exp = {5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; total++;
    if (got !== exp) begin bad++; $display("FAIL rstmid_cleared: got %h exp %h", got, exp); end
    total++;
    if (wd !== 64'h0) begin bad++; $display("FAIL rstmid_wd: got %h exp 0", wd); end
    rst = 1'b1;
    tick();
    got = obs(); total++;
    if (got !== exp) begin bad++; $display("FAIL rstmid_no_write: got %h exp %h", got, exp); end
    data_valid = 1'b0;
    set_cmd(5'd16, 3'b000, 3'b001, 7'd12);
    tick();
    cmd_valid = 1'b0;
    data_valid = 1'b1; data_in = 64'h1;
    tick();
    got = obs(); exp = {5'd16, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; total++;
    if (got !== exp) begin bad++; $display("FAIL rstmid_restart0: got %h exp %h", got, exp); end
    data_in = 64'h2;
    tick();
    data_valid = 1'b0;
    got = obs(); exp = {5'd17, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; total++;
    if (got !== exp) begin bad++; $display("FAIL rstmid_restart1: got %h exp %h", got, exp); end
  endtask

  task automatic test_saturate();
    set_cmd(5'd0, 3'b011, 3'b000, 7'd100);
    tick();
    cmd_valid = 1'b0;
    data_valid = 1'b1; data_in = 64'hFEDC_BA98_7654_3210;
    tick();
    data_valid = 1'b0;
    got = obs(); exp = {5'd0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; total++;
    if (got !== exp) begin bad++; $display("FAIL saturate: got %h exp %h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_reject();
    test_reset_mid();
    test_saturate();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vreg_writeback_sequencer.md
Name: vreg_writeback_sequencer

Overview:
- Write-back end of the vector pipeline; inverse of the grouping read path.
- Accepts one write-back command (dest group, SEW, LMUL, vl), then LMUL 64-bit result beats from the vALU.
- Drives the vRegFile write port (wa/wd/wen) plus a per-byte enable that leaves tail elements (index >= vl) undisturbed.
- Walks dest, dest+1, ... across the register group, one register per accepted beat.

Parameters:
- VLEN, 64, vector register width in bits; byte-enable width is VLEN/8.
- RA_W, 5, register address width.
- VL_W, 7, vl field width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can take a command (high only in IDLE)
- cmd_dest  in  RA_W  base destination register of the group
- cmd_sew  in  3  encoded SEW: 000=8, 001=16, 010=32, 011=64
- cmd_lmul  in  3  encoded LMUL: 000=1, 001=2, 010=4, 011=8
- cmd_vl  in  VL_W  active vector length in elements
- data_valid  in  1  result beat offered
- data_ready  out  1  beat accepted this cycle when high with data_valid (high only in BEAT)
- data_in  in  VLEN  result beat
- wa  out  RA_W  register-file write address
- wd  out  VLEN  register-file write data
- wen  out  1  register-file write enable
- wbe  out  VLEN/8  per-byte write enable
- done  out  1  one-cycle pulse when the command completes
- err  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, beat counter=0, wa=0, wd=0, wen=0, wbe=0, done=0, err=0. Outputs become cmd_ready=1 and data_ready=0 from the next cycle. Applies mid-command: the in-flight command is abandoned and no further writes are issued.
- States: IDLE, BEAT.
- IDLE, cmd_valid & cmd_ready: latch dest, SEW, LMUL and vl.
  - Reserved SEW/LMUL (1xx), or cmd_dest not a multiple of LMUL: err=1 next cycle, stay IDLE, no writes.
  - cmd_vl==0: done=1 next cycle, stay IDLE, no writes.
  - Otherwise: enter BEAT, beat=0.
- BEAT: data_ready=1. Per accepted beat k (0..LMUL-1), outputs are registered and visible the next cycle:
  - wa=dest+k, wd=data_in.
  - wbe[b]=1 iff (k*(VLEN/SEW) + b/(SEW/8)) < vl.
  - wen = (wbe != 0).
- Beats with all-zero wbe are still consumed (data_ready=1) but produce wen=0.
- If data_valid=0 in BEAT: hold state and counter; wen=0, done=0.
- The last beat (k==LMUL-1) returns to IDLE. done=1 in the same cycle as that beat's write outputs. cmd_ready=1 again in that same cycle, so back-to-back commands have no bubble.
- wen/done/err are single-cycle pulses. wa/wd/wbe hold their last values while wen=0.
- cmd_valid in BEAT is ignored; the command must be held until cmd_ready.
- vl > VLMAX (LMUL*VLEN/SEW) saturates naturally: every byte is enabled. No error.
- Element-index arithmetic uses at least 8 bits (max 8*8=64 elements, compared against 7-bit vl).
- dest+k never wraps: alignment guarantees dest+LMUL-1 <= 31.

Test Plan:
- Basic element masking: cmd dest=3, SEW=8 (000), LMUL=1 (000), vl=5; one beat 0x1122334455667788 -> next cycle wa=3, wd=0x1122334455667788, wbe=0x1F, wen=1, done=1.
- Register grouping with tail: dest=8, SEW=32, LMUL=4, vl=5; 4 beats back-to-back -> wa 8,9,10,11; wbe 0xFF, 0xFF, 0x0F, 0x00; wen 1,1,1,0; done with the 4th beat; cmd_ready=1 in the same cycle.
- Backpressure: dest=4, SEW=16, LMUL=2, vl=8; data_valid toggles 1,0,0,1 -> exactly two writes (wa=4 wbe=0xFF; wa=5 wbe=0xFF), no outputs during the gaps, done after the second write.
- Rejection: dest=3, LMUL=2 -> err pulse, no wen, cmd_ready stays 1. SEW=100 -> err. vl=0 -> done pulse, no wen.
- Reset mid-command: LMUL=8 command, reset asserted after 3 beats -> no further wen, outputs zero, next command starts from beat 0.
- Saturation: dest=0, SEW=64, LMUL=1, vl=100 -> wbe=0xFF, wen=1, done=1.
